// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit paths.
// Holds the receiver FSM state type and the default frame/oversampling sizes.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OSR      = 16;
    localparam int DATA_W   = 8;
    localparam int MID_TICK = OSR / 2 - 1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: DEPTH entries, first-word fall-through head, wrap-bit pointers.
// Ports: push/data in, pop in, head out, full/empty/count out, overflow out.
module rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [$clog2(DEPTH):0] count,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              pop_ok;
    logic              push_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign head  = mem[rptr[AW-1:0]];

    // A pop in the same cycle frees a slot, so a push into a full
    // FIFO is still accepted then.
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign overflow = push && full && !pop_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr              <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 frame recovery into an 8-entry FIFO.
// Ports: clk/rst_n, baud_tick, rxd, rd_rcv_fifo, err_clr; FIFO head/flags/count, sticky errors.
module uart_rx #(
    parameter int DATA_W = uart_pkg::DATA_W,
    parameter int DEPTH  = 8,
    parameter int OSR    = uart_pkg::OSR
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    baud_tick,
    input  logic                    rxd,
    input  logic                    rd_rcv_fifo,
    input  logic                    err_clr,
    output logic [DATA_W-1:0]       rcv_fifo_data,
    output logic                    rf_full,
    output logic                    rf_empty,
    output logic [$clog2(DEPTH):0]  rf_count,
    output logic                    framing_err,
    output logic                    overrun_err
);

    import uart_pkg::*;

    localparam int TW = $clog2(OSR);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TW-1:0] MID  = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OSR - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    rx_state_t         state;
    logic              sync1;
    logic              sync2;
    logic              prev;
    logic [TW-1:0]     tick_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              fall;
    logic              stop_smp;
    logic              push;
    logic              bad_stop;
    logic              overflow;

    assign fall     = prev && !sync2;
    assign stop_smp = (state == STOP) && baud_tick && (tick_cnt == LAST);
    assign push     = stop_smp && sync2;
    assign bad_stop = stop_smp && !sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fall) begin
                        state <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tick_cnt == MID) begin
                            tick_cnt <= '0;
                            // A high line at mid-start is a glitch.
                            state    <= sync2 ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (tick_cnt == LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {sync2, shreg[DATA_W-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (tick_cnt == LAST) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    // Sticky flags: a new event wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (bad_stop) begin
                framing_err <= 1'b1;
            end else if (err_clr) begin
                framing_err <= 1'b0;
            end
            if (overflow) begin
                overrun_err <= 1'b1;
            end else if (err_clr) begin
                overrun_err <= 1'b0;
            end
        end
    end

    rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shreg),
        .pop       (rd_rcv_fifo),
        .head      (rcv_fifo_data),
        .full      (rf_full),
        .empty     (rf_empty),
        .count     (rf_count),
        .overflow  (overflow)
    );

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive path of the UART. The block oversamples the serial input `rxd` at 16x, recovers 8N1 frames with an IDLE/START/DATA/STOP state machine, and pushes each good byte into an internal 8-entry receive FIFO. The host side pops bytes from that FIFO, which makes it the counterpart of the transmit FIFO / parallel-to-serial path. Framing errors and overruns are reported through sticky flags.

## Interface
Parameters:
- `DATA_W`, 8: payload bits per frame, sent LSB first.
- `DEPTH`, 8: receive FIFO entries; must be a power of 2.
- `OSR`, 16: `baud_tick` pulses per bit time.

Ports:
- `clk`  in  1  system clock. One clock domain; everything is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `baud_tick`  in  1  single-cycle enable at OSR × baud rate.
- `rxd`  in  1  asynchronous serial line; idles high.
- `rd_rcv_fifo`  in  1  pop request from the host.
- `err_clr`  in  1  clears both sticky error flags.
- `rcv_fifo_data`  out  DATA_W  head of the FIFO (first-word fall-through).
- `rf_full`  out  1  FIFO holds DEPTH entries.
- `rf_empty`  out  1  FIFO holds 0 entries.
- `rf_count`  out  $clog2(DEPTH)+1  number of entries, 0..DEPTH.
- `framing_err`  out  1  sticky; a stop bit was sampled low.
- `overrun_err`  out  1  sticky; a good frame arrived while the FIFO was full.

## Operation
- **Synchronizer:** `rxd` passes through a 2-flop synchronizer, reset to 1. A third flop holds the previous synchronized value for falling-edge detection.
- **Bit timing:** a 4-bit tick counter advances only on `baud_tick` and is cleared on every state change.
- **IDLE:** moves to START on a synchronized falling edge, i.e. previous value 1 and current value 0. A line held low (break) never retriggers.
- **START:** on the tick where the counter reaches OSR/2−1 (7), the synchronized line is sampled.
  - Low: move to DATA with the counter cleared.
  - High: false start; return to IDLE with no flag set.
- **DATA:** every OSR ticks (counter = 15), the line is sampled and shifted in LSB first. After DATA_W samples, move to STOP.
- **STOP:** the line is sampled at counter = 15.
  - High and FIFO not full: push the byte.
  - High and FIFO full: drop the byte and set `overrun_err`.
  - Low: discard the byte and set `framing_err`.
  - In every case, return to IDLE.
- **FIFO storage:** read and write pointers are log2(DEPTH)+1 bits wide and wrap naturally.
  - `rf_full` asserts when the pointer MSBs differ and the remaining bits are equal.
  - `rf_empty` asserts when the pointers are equal.
- **Pop:** `rd_rcv_fifo` while `rf_empty` is high is ignored; pointers and data do not change.
- **Simultaneous push and pop:**
  - Both are performed and `rf_count` is unchanged.
  - This also applies when the FIFO is full: the push is accepted because a slot is freed that cycle, and no overrun is flagged.
- **Sticky error flags:** if `err_clr` and a new error event occur in the same cycle, set wins.
- **Reset:** asserting `rst_n` mid-frame aborts the frame. FIFO contents are lost and the FSM goes to IDLE.

## Timing
Reset values:
- `rcv_fifo_data` = 0
- `rf_empty` = 1
- `rf_full` = 0
- `rf_count` = 0
- `framing_err` = 0
- `overrun_err` = 0
- FSM in IDLE, pointers 0, shift register 0, synchronizer flops 1.

Latency:
- `rxd` edge to detection: 2 `clk` cycles of synchronizer, plus wait for the next `baud_tick`.
- The push is registered on the `clk` edge of the stop-sample tick. `rf_empty`, `rf_count` and `rcv_fifo_data` reflect the new entry on the following cycle.
- A pop takes effect on the `clk` edge where `rd_rcv_fifo` is high. The next head appears on `rcv_fifo_data` in the cycle after.

Other rules:
- `rf_count`, `rf_full` and `rf_empty` are registered or derived from registered pointers. None of them depends combinationally on `rd_rcv_fifo`.
- A frame's full length is 1 + DATA_W + 1 bit times. The FSM returns to IDLE mid-stop-bit, so back-to-back frames are accepted.

## Structure
- Shared package `uart_pkg`, also used by the transmit side:
  - FSM state enum `rx_state_t` {IDLE, START, DATA, STOP}
  - `OSR` and `DATA_W` defaults
  - localparam `MID_TICK = OSR/2-1`
- Sub-module `rx_fifo` holds the FIFO: storage, pointers, count and flags, with push/pop ports. `uart_rx` instantiates it alongside the synchronizer and FSM.

## Test plan
All scenarios run with `baud_tick` high every `clk` cycle.
- **Single frame:** send 0xA5 (start, 1,0,1,0,0,1,0,1, stop).
  - Required: one cycle after the stop sample, `rf_count`=1, `rf_empty`=0, `rcv_fifo_data`=0xA5, both error flags 0.
- **Fill and overrun:** send 0x01..0x09 back-to-back with no pops.
  - After the eighth frame: `rf_full`=1, `rf_count`=8.
  - The ninth frame sets `overrun_err`.
  - Popping 8 times returns 0x01..0x08 in order, then `rf_empty`=1.
- **Framing error:** send 0x3C with the stop bit low, then `rxd` high.
  - Required: `framing_err`=1, `rf_count` unchanged.
  - A following good frame 0x55 is received, and `err_clr` then clears the flag.
- **Glitch and pop on empty:** drive `rxd` low for 4 ticks, then high.
  - Required: START aborts to IDLE, no push, no flags.
  - `rd_rcv_fifo` pulsed while empty leaves `rf_count`=0.
- **Push and pop at full:** with the FIFO full, pop in the exact cycle the stop sample of frame 0x77 pushes.
  - Required: `rf_count` stays 8, `overrun_err`=0, and 0x77 is the last entry.
- **Reset mid-frame:** assert `rst_n` low mid-DATA of frame 0xF0, release, then send 0x12.
  - Required: all outputs at reset values after reset, then only 0x12 is received.
